paula_floppy_dma_ctrl: RTL and testbench
========================================

// Module: paula_floppy_dma_ctrl
//
// PURPOSE
// - Sequences disk DMA between the 2048x16 floppy FIFO and chip RAM DMA slots.
// - Decodes DSKLEN (DMAEN/WRITE/LEN) and applies the double-write arm rule.
// - In read mode, drains FIFO words to memory; in write mode, fills the FIFO from memory.
// - Counts words, raises the disk-block-done interrupt, and sits between the DSKLEN register path, the Agnus slot grant and the FIFO.
//
// PARAMETERS
// - LEN_W     14    DSKLEN word-count width
// - CNT_W     12    FIFO occupancy width (matches FIFO cnt port)
// - WR_HIWAT  2040  write mode: no dmareq while fifo_cnt >= WR_HIWAT
//
// PORTS
// - clk          in   1      bus clock
// - reset_n      in   1      asynchronous active-low reset
// - clk7_en      in   1      clock enable; all state advances only when 1
// - dsklen_wr    in   1      DSKLEN write strobe
// - data_in      in   16     DSKLEN write data: [15]=DMAEN, [14]=WRITE, [13:0]=LEN
// - dmaslot      in   1      Agnus grants the disk DMA slot this cycle
// - fifo_empty   in   1      FIFO empty flag (one-cycle delayed)
// - fifo_full    in   1      FIFO full flag
// - fifo_cnt     in   CNT_W  FIFO entry count
// - dmareq       out  1      request a disk DMA slot
// - dma_dir      out  1      1 = memory->disk (write), 0 = disk->memory
// - fifo_rd      out  1      pop one FIFO word
// - fifo_wr      out  1      push the bus word into the FIFO
// - fifo_reset   out  1      one-cycle FIFO flush
// - dma_active   out  1      transfer in progress (XFER or DRAIN)
// - blkdone      out  1      one-cycle DSKBLK interrupt pulse
//
// BEHAVIOUR
// - Reset: state=IDLE, all outputs 0, armed=0, wcnt=0. Async assert, synchronous release.
// - Everything below happens only on clk7_en=1 cycles. Output pulses last exactly one enabled cycle.
// - States: IDLE, ARMED, XFER, DRAIN, DONE.
// - A dsklen_wr with DMAEN=0, in any state:
//   - go to IDLE; fifo_reset=1 for one cycle; clear armed.
//   - If the block was in XFER or DRAIN, do NOT pulse blkdone.
// - IDLE, dsklen_wr with DMAEN=1:
//   - latch WRITE into dma_dir and LEN into wcnt; go to ARMED.
// - ARMED, dsklen_wr with DMAEN=1:
//   - relatch dma_dir and wcnt.
//   - If LEN==0, go to DONE; otherwise go to XFER and pulse fifo_reset.
// - A dsklen_wr with DMAEN=1 while in XFER or DRAIN is ignored.
// - XFER, read mode (dma_dir=0):
//   - dmareq = !fifo_empty.
//   - dmaslot & dmareq -> fifo_rd=1 in the same cycle; wcnt decrements.
// - XFER, write mode (dma_dir=1):
//   - dmareq = !fifo_full & (fifo_cnt < WR_HIWAT).
//   - dmaslot & dmareq -> fifo_wr=1 in the same cycle; wcnt decrements.
// - A dmaslot with dmareq=0 is ignored; no pointer moves.
// - Ending XFER:
//   - wcnt reaching 0 in read mode -> DONE.
//   - wcnt reaching 0 in write mode -> DRAIN.
// - DRAIN (write mode only): dmareq=0; stay until fifo_empty=1 (disk consumed all words), then go to DONE.
// - DONE: blkdone=1 for one cycle; go to IDLE.
// - A dsklen_wr and dmaslot in the same cycle: the register write wins and the slot is ignored.
// - At most one fifo_rd/fifo_wr per enabled cycle; the two are never asserted together.
// - wcnt is LEN_W bits, decrements toward 0 and never wraps.
// - dma_active = (state==XFER)|(state==DRAIN).
// - dmareq=0 in every state except XFER.
//
// STRUCTURE
// - Shared package paula_floppy_pkg holds:
//   - DSKLEN field constants: DSKLEN_DMAEN=15, DSKLEN_WRITE=14, LEN msb=13.
//   - State enum/localparams: ST_IDLE, ST_ARMED, ST_XFER, ST_DRAIN, ST_DONE.
// - Single flat module: FSM, word counter and request logic. No sub-module.
// - The FIFO is instantiated by the parent, not inside this block.
//
// TESTING
// - Arm/start, read mode:
//   - stimulus: two dsklen_wr of 0x8004, FIFO preloaded with 6 words, dmaslot every cycle.
//   - expect: exactly 4 fifo_rd pulses, then blkdone once; fifo_cnt ends at 2.
// - Single write:
//   - stimulus: one dsklen_wr of 0x8004, then 10 dmaslot cycles.
//   - expect: state=ARMED; no dmareq, no fifo_rd, no fifo_wr.
// - Write mode with drain:
//   - stimulus: two dsklen_wr of 0xC003, dmaslot every cycle.
//   - expect: 3 fifo_wr pulses; blkdone only after fifo_empty=1.
// - Write mode high-water:
//   - stimulus: fifo_cnt=2040.
//   - expect: dmareq=0; dmareq rises when fifo_cnt drops to 2039.
// - Abort:
//   - stimulus: dsklen_wr of 0x0000 mid-XFER with wcnt=100.
//   - expect: fifo_reset pulse, IDLE, no blkdone.
// - LEN=0, then reset:
//   - stimulus: two dsklen_wr of 0x8000, then reset_n low mid-XFER.
//   - expect: 0x8000 gives blkdone with zero FIFO ops; reset_n low clears all outputs asynchronously.

Source files
------------

// File: rtl/paula_floppy_pkg.sv
// Shared definitions for the Paula floppy DMA path: DSKLEN field positions
// and the DMA sequencer state encoding.
package paula_floppy_pkg;

  localparam int DSKLEN_DMAEN   = 15;
  localparam int DSKLEN_WRITE   = 14;
  localparam int DSKLEN_LEN_MSB = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/paula_floppy_dma_ctrl.sv
// Disk DMA sequencer: DSKLEN double-write arming, word counting, FIFO
// read/write requests against Agnus slot grants, and DSKBLK pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no transfer; first DSKLEN write with DMAEN arms
// ST_ARMED | one DMAEN write seen; second one starts the block
// ST_XFER  | moving words between FIFO and chip RAM
// ST_DRAIN | write mode, all words fetched; wait for disk to empty FIFO
// ST_DONE  | block complete; raise blkdone once and return to idle
module paula_floppy_dma_ctrl
  import paula_floppy_pkg::*;
#(
  parameter int LEN_W    = 14,
  parameter int CNT_W    = 12,
  parameter int WR_HIWAT = 2040
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk7_en,
  input  logic             dsklen_wr,
  input  logic [15:0]      data_in,
  input  logic             dmaslot,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic [CNT_W-1:0] fifo_cnt,
  output logic             dmareq,
  output logic             dma_dir,
  output logic             fifo_rd,
  output logic             fifo_wr,
  output logic             fifo_reset,
  output logic             dma_active,
  output logic             blkdone
);

  state_t           r_state;
  logic             r_dir;
  logic [LEN_W-1:0] r_wcnt;
  logic             r_fifo_reset;
  logic             r_blkdone;

  logic             w_dmaen;
  logic             w_write;
  logic [LEN_W-1:0] w_len;
  logic             w_xfer;
  logic             w_below_hiwat;
  logic             w_req;
  logic             w_take;

  assign w_dmaen       = data_in[DSKLEN_DMAEN];
  assign w_write       = data_in[DSKLEN_WRITE];
  assign w_len         = data_in[LEN_W-1:0];
  assign w_xfer        = (r_state == ST_XFER);
  assign w_below_hiwat = (fifo_cnt < CNT_W'(WR_HIWAT));

  // Request is a level; the grant only counts on an enabled cycle without a
  // competing register write, which always takes priority over the slot.
  assign w_req  = w_xfer & (r_dir ? (~fifo_full & w_below_hiwat) : ~fifo_empty);
  assign w_take = clk7_en & dmaslot & w_req & ~dsklen_wr;

  assign dmareq     = w_req;
  assign fifo_rd    = w_take & ~r_dir;
  assign fifo_wr    = w_take &  r_dir;
  assign dma_dir    = r_dir;
  assign fifo_reset = r_fifo_reset;
  assign blkdone    = r_blkdone;
  assign dma_active = (r_state == ST_XFER) | (r_state == ST_DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_dir        <= 1'b0;
      r_wcnt       <= '0;
      r_fifo_reset <= 1'b0;
      r_blkdone    <= 1'b0;
    end else if (clk7_en) begin
      r_fifo_reset <= 1'b0;
      r_blkdone    <= 1'b0;
      if (dsklen_wr && !w_dmaen) begin
        r_state      <= ST_IDLE;
        r_fifo_reset <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (dsklen_wr) begin
              r_dir   <= w_write;
              r_wcnt  <= w_len;
              r_state <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (dsklen_wr) begin
              r_dir  <= w_write;
              r_wcnt <= w_len;
              if (w_len == '0) begin
                r_state <= ST_DONE;
              end else begin
                r_state      <= ST_XFER;
                r_fifo_reset <= 1'b1;
              end
            end
          end
          ST_XFER: begin
            if (w_take) begin
              if (r_wcnt != '0) r_wcnt <= r_wcnt - LEN_W'(1);
              if (r_wcnt == LEN_W'(1)) r_state <= r_dir ? ST_DRAIN : ST_DONE;
            end
          end
          ST_DRAIN: begin
            if (fifo_empty) r_state <= ST_DONE;
          end
          ST_DONE: begin
            r_blkdone <= 1'b1;
            r_state   <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_paula_floppy_dma_ctrl.sv
// Directed bench for paula_floppy_dma_ctrl with a small occupancy model of
// the disk FIFO driven from the same initial block.
module tb_paula_floppy_dma_ctrl;
  import paula_floppy_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk7_en;
  logic        dsklen_wr;
  logic [15:0] data_in;
  logic        dmaslot;
  logic        fifo_empty;
  logic        fifo_full;
  logic [11:0] fifo_cnt;
  logic        dmareq, dma_dir, fifo_rd, fifo_wr, fifo_reset, dma_active, blkdone;

  int total = 0;
  int bad   = 0;
  int mcnt  = 0;
  int n_rd, n_wr, n_rst, n_blk, n_req;

  paula_floppy_dma_ctrl #(.LEN_W(14), .CNT_W(12), .WR_HIWAT(2040)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk7_en    (clk7_en),
    .dsklen_wr  (dsklen_wr),
    .data_in    (data_in),
    .dmaslot    (dmaslot),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_cnt   (fifo_cnt),
    .dmareq     (dmareq),
    .dma_dir    (dma_dir),
    .fifo_rd    (fifo_rd),
    .fifo_wr    (fifo_wr),
    .fifo_reset (fifo_reset),
    .dma_active (dma_active),
    .blkdone    (blkdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fifo(input int n);
    mcnt       = n;
    fifo_cnt   = 12'(n);
    fifo_empty = (n == 0);
  endtask

  task automatic clr_counts();
    n_rd = 0; n_wr = 0; n_rst = 0; n_blk = 0; n_req = 0;
  endtask

  // One clock: sample mid-cycle, then apply the FIFO model at the edge.
  task automatic cyc();
    logic s_rd, s_wr, s_rst;
    @(negedge clk);
    s_rd = fifo_rd; s_wr = fifo_wr; s_rst = fifo_reset;
    if (fifo_rd)    n_rd++;
    if (fifo_wr)    n_wr++;
    if (fifo_reset) n_rst++;
    if (blkdone)    n_blk++;
    if (dmareq)     n_req++;
    @(posedge clk);
    if (clk7_en) begin
      if (s_rst) mcnt = 0;
      else begin
        if (s_rd) mcnt--;
        if (s_wr) mcnt++;
      end
    end
    #1;
    set_fifo(mcnt);
  endtask

  task automatic wr_len(input logic [15:0] v);
    dsklen_wr = 1'b1;
    data_in   = v;
    cyc();
    dsklen_wr = 1'b0;
    data_in   = 16'h0;
  endtask

  initial begin
    reset_n = 1'b0; clk7_en = 1'b1; dsklen_wr = 1'b0; data_in = 16'h0;
    dmaslot = 1'b0; fifo_full = 1'b0;
    set_fifo(0);
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {25'd0, dmareq, dma_dir, fifo_rd, fifo_wr, fifo_reset, dma_active, blkdone}, 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rst_wcnt", 32'(dut.r_wcnt), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Read mode: arm, start, 6 words buffered, LEN=4
    wr_len(16'h8004);
    chk("rd_armed", 32'(dut.r_state), 32'(ST_ARMED));
    wr_len(16'h8004);
    chk("rd_active", 32'(dma_active), 32'd1);
    chk("rd_dir", 32'(dma_dir), 32'd0);
    clr_counts();
    cyc();
    chk("rd_start_flush", 32'(n_rst), 32'd1);
    set_fifo(6);
    dmaslot = 1'b1;
    clr_counts();
    repeat (20) cyc();
    chk("rd_pops", 32'(n_rd), 32'd4);
    chk("rd_blkdone", 32'(n_blk), 32'd1);
    chk("rd_fifo_left", 32'(mcnt), 32'd2);
    chk("rd_end_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Single DSKLEN write only arms
    dmaslot = 1'b0;
    wr_len(16'h8004);
    dmaslot = 1'b1;
    clr_counts();
    repeat (10) cyc();
    chk("single_state", 32'(dut.r_state), 32'(ST_ARMED));
    chk("single_ops", 32'(n_req + n_rd + n_wr), 32'd0);
    dmaslot = 1'b0;
    clr_counts();
    wr_len(16'h0000);
    cyc();
    chk("single_cancel_flush", 32'(n_rst), 32'd1);
    chk("single_cancel_state", 32'(dut.r_state), 32'(ST_IDLE));

    // clk7_en low freezes everything
    clk7_en = 1'b0;
    wr_len(16'h8004);
    chk("en_low_hold", 32'(dut.r_state), 32'(ST_IDLE));
    clk7_en = 1'b1;

    // Write mode with drain, LEN=3
    wr_len(16'hC003);
    wr_len(16'hC003);
    cyc();
    chk("wr_dir", 32'(dma_dir), 32'd1);
    dmaslot = 1'b1;
    clr_counts();
    wr_len(16'hC005);
    chk("wr_ignore_state", 32'(dut.r_state), 32'(ST_XFER));
    chk("wr_ignore_wcnt", 32'(dut.r_wcnt), 32'd3);
    chk("wr_regwin_slot", 32'(n_wr), 32'd0);
    repeat (10) cyc();
    chk("wr_pushes", 32'(n_wr), 32'd3);
    chk("wr_no_early_blk", 32'(n_blk), 32'd0);
    chk("wr_drain_state", 32'(dut.r_state), 32'(ST_DRAIN));
    chk("wr_drain_noreq", 32'(dmareq), 32'd0);
    chk("wr_drain_active", 32'(dma_active), 32'd1);
    set_fifo(0);
    clr_counts();
    repeat (5) cyc();
    chk("wr_blk_after_empty", 32'(n_blk), 32'd1);
    chk("wr_end_state", 32'(dut.r_state), 32'(ST_IDLE));

    // High-water mark, LEN=100, then abort
    dmaslot = 1'b0;
    wr_len(16'hC064);
    wr_len(16'hC064);
    cyc();
    set_fifo(2040);
    dmaslot = 1'b1;
    #1;
    chk("hiwat_2040_req", 32'(dmareq), 32'd0);
    clr_counts();
    cyc();
    chk("hiwat_no_push", 32'(n_wr), 32'd0);
    dmaslot = 1'b0;
    set_fifo(2039);
    #1;
    chk("hiwat_2039_req", 32'(dmareq), 32'd1);
    fifo_full = 1'b1;
    #1;
    chk("full_blocks_req", 32'(dmareq), 32'd0);
    fifo_full = 1'b0;
    chk("abort_wcnt", 32'(dut.r_wcnt), 32'd100);
    clr_counts();
    wr_len(16'h0000);
    repeat (5) cyc();
    chk("abort_flush", 32'(n_rst), 32'd1);
    chk("abort_no_blk", 32'(n_blk), 32'd0);
    chk("abort_state", 32'(dut.r_state), 32'(ST_IDLE));

    // LEN=0 completes immediately without FIFO traffic
    dmaslot = 1'b1;
    clr_counts();
    wr_len(16'h8000);
    wr_len(16'h8000);
    repeat (3) cyc();
    chk("len0_blk", 32'(n_blk), 32'd1);
    chk("len0_fifo_ops", 32'(n_rd + n_wr + n_rst), 32'd0);

    // Async reset in the middle of a write transfer
    dmaslot = 1'b0;
    wr_len(16'hC00A);
    wr_len(16'hC00A);
    cyc();
    set_fifo(5);
    dmaslot = 1'b1;
    repeat (2) cyc();
    chk("pre_rst_push", 32'(fifo_wr), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_outputs", {25'd0, dmareq, dma_dir, fifo_rd, fifo_wr, fifo_reset, dma_active, blkdone}, 32'd0);
    chk("async_rst_state", 32'(dut.r_state), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
